// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, 64-line direct-mapped instruction cache
// and a single outstanding miss towards the memory controller.
module if_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        jump_enable,
   input  logic [31:0] jump_target,
   input  logic [5:0]  stall_ctrler,
   input  logic        mem_done,
   input  logic [31:0] mem_inst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        stall_req
);

   typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [63:0] valid_q, valid_d;
   logic        pend_q, pend_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] mem_addr_q, mem_addr_d;

   logic [9:0]  tag_mem  [64];
   logic [31:0] data_mem [64];

   logic [5:0]  idx_s;
   logic [5:0]  fill_idx_s;
   logic        hit_s;
   logic        fill_s;
   logic        unused_s;

   assign idx_s      = pc_q[7:2];
   assign fill_idx_s = mem_addr_q[7:2];
   assign hit_s      = valid_q[idx_s] && (tag_mem[idx_s] == pc_q[17:8]);
   assign unused_s   = ^stall_ctrler[5:1];

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign if_pc    = (if_inst != 32'd0) ? pc_q : 32'd0;

   // Next-state, cache fill strobe and combinational fetch outputs.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      valid_d    = valid_q;
      pend_d     = pend_q;
      pend_pc_d  = pend_pc_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      fill_s     = 1'b0;
      if_inst    = 32'd0;
      stall_req  = 1'b0;

      if (rst) begin
         fill_s = 1'b0;
      end else if (!rdy) begin
         stall_req = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (jump_enable) begin
                  pc_d = jump_target;
               end else if (hit_s) begin
                  if_inst = data_mem[idx_s];
                  if (!stall_ctrler[0]) begin
                     pc_d = pc_q + 32'd4;
                  end else begin
                     pc_d = pc_q;
                  end
               end else begin
                  stall_req  = 1'b1;
                  mem_req_d  = 1'b1;
                  mem_addr_d = pc_q;
                  state_d    = WAIT_MEM;
               end
            end
            WAIT_MEM: begin
               stall_req = 1'b1;
               if (mem_done) begin
                  fill_s              = 1'b1;
                  valid_d[fill_idx_s] = 1'b1;
                  mem_req_d           = 1'b0;
                  state_d             = IDLE;
                  pend_d              = 1'b0;
                  // A redirect that arrived during the miss takes effect only after the fill.
                  if (jump_enable) begin
                     pc_d = jump_target;
                  end else if (pend_q) begin
                     pc_d = pend_pc_q;
                  end else begin
                     pc_d = pc_q;
                  end
               end else if (jump_enable) begin
                  pend_d    = 1'b1;
                  pend_pc_d = jump_target;
               end else begin
                  pend_d = pend_q;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Control and PC registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_q       <= 32'd0;
         valid_q    <= 64'd0;
         pend_q     <= 1'b0;
         pend_pc_q  <= 32'd0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         pend_q     <= pend_d;
         pend_pc_q  <= pend_pc_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   // Cache tag/data arrays; only the valid bits carry reset state.
   always_ff @(posedge clk) begin
      if (fill_s) begin
         tag_mem[fill_idx_s]  <= mem_addr_q[17:8];
         data_mem[fill_idx_s] <= mem_inst;
      end
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 rdy  input  1  global ready; when low, all state holds and no new memory request is issued.
REQ-004 jump_enable  input  1  redirect from EX; high for one cycle when a taken branch or jump resolves.
REQ-005 jump_target  input  32  redirect PC, valid while jump_enable is high.
REQ-006 stall_ctrler  input  6  stall vector; bit 0 holds the PC/fetch stage.
REQ-007 mem_done  input  1  one-cycle pulse from the memory controller: fetch data valid.
REQ-008 mem_inst  input  32  fetched instruction word, valid with mem_done.
REQ-009 mem_req  output  1  registered fetch request to the memory controller.
REQ-010 mem_addr  output  32  registered fetch address, held stable while mem_req is high.
REQ-011 if_pc  output  32  PC of the delivered instruction, to IF_ID.
REQ-012 if_inst  output  32  delivered instruction word; 0 means bubble.
REQ-013 stall_req  output  1  request to the stall controller to freeze fetch and IF_ID (cache miss in flight).

Function
REQ-014 The block SHALL hold a 32-bit PC register, a two-state FSM (IDLE, WAIT_MEM) and a 64-entry direct-mapped instruction cache: index = pc[7:2], tag = pc[17:8], one valid bit per line.
REQ-015 Hit = valid[index] and tag match; it SHALL be evaluated combinationally on the current PC in IDLE.
REQ-016 In IDLE on a hit, with stall_ctrler[0] low and jump_enable low: if_pc = PC, if_inst = the cached word, stall_req = 0, and PC <= PC+4 at the clock edge (32-bit wrap, no carry out).
REQ-017 In IDLE on a hit with stall_ctrler[0] high: PC holds, and the outputs still present the hit word (IF_ID holds on its own).
REQ-018 In IDLE on a miss with jump_enable low: if_inst = 0, stall_req = 1; at the edge mem_req <= 1, mem_addr <= PC, FSM -> WAIT_MEM.
REQ-019 In WAIT_MEM: mem_req and mem_addr SHALL stay constant, if_inst = 0, stall_req = 1, and PC holds.
REQ-020 On mem_done in WAIT_MEM: write mem_inst into the line for mem_addr and set its valid bit; mem_req <= 0; FSM -> IDLE. The instruction is delivered next cycle as a hit.
REQ-021 jump_enable in IDLE SHALL take priority over hit and miss handling:
  - PC <= jump_target; if_inst = 0; no request is issued that cycle.
REQ-022 jump_enable in WAIT_MEM SHALL NOT abort the transaction:
  - the target is latched into a pending-redirect register;
  - on mem_done the fill still completes, then PC <= the latched target.
REQ-023 jump_enable coincident with mem_done SHALL behave as REQ-022: fill, then PC <= jump_target.
REQ-024 A second jump_enable while a redirect is already pending SHALL overwrite it (latest wins).
REQ-025 mem_done outside WAIT_MEM SHALL be ignored, with no cache write.
REQ-026 With rdy low, PC, FSM, cache, pending redirect, mem_req and mem_addr all hold; if_inst = 0 and stall_req = 1.
REQ-027 if_pc SHALL equal PC whenever if_inst is non-zero; otherwise if_pc = 0.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL set:
  - PC = 0, FSM = IDLE, all valid bits = 0;
  - pending redirect cleared, mem_req = 0, mem_addr = 0.
REQ-029 While rst is high, the combinational outputs SHALL be forced to if_pc = 0, if_inst = 0, stall_req = 0.
REQ-030 Reset asserted in WAIT_MEM SHALL abandon the fetch; a later mem_done is ignored per REQ-025.
REQ-031 Cache contents outside the valid bits need no reset.

Verification
REQ-032 Cold start: release reset; memory returns 0x00000013 three cycles after the request -> mem_req=1 with mem_addr=0 on the first cycle, stall_req=1 until mem_done, then if_pc=0, if_inst=0x00000013, and PC becomes 4.
REQ-033 Warm loop: the lines for 0x0 and 0x4 are filled; jump_enable=1 with target 0 each time PC reaches 0x8 -> instructions delivered back-to-back with no mem_req and stall_req=0 while hitting.
REQ-034 Redirect during a miss: jump_enable=1 with target 0x100 in the second WAIT_MEM cycle for addr 0x40 -> the fill of 0x40 completes, then PC=0x100, and the next request goes to 0x100.
REQ-035 Alias: fill 0x000, then fetch 0x100 (same index, different tag) -> miss, refill; a later fetch of 0x000 misses again.
REQ-036 Stall and rdy: stall_ctrler[0]=1 for 3 cycles on a hit -> PC constant and outputs stable; rdy=0 in WAIT_MEM with a coincident mem_done -> the pulse is lost by design and the transaction does not complete (the memory controller also honours rdy).
REQ-037 Reset mid-miss: rst=1 in WAIT_MEM, then mem_done arrives after release -> no cache write, and a fresh request is issued to addr 0.
